// File: rtl/sc_sng_pkg.sv
// Shared types and constants for the stochastic stream generator: FSM states,
// Galois tap masks by width, and the LFSR seed table.
package sc_sng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sng_state_t;

    // Variable seeds have distinct nonzero low nibbles, so they stay distinct at any width >= 4.
    localparam int MAX_VARS = 8;
    localparam logic [15:0] VAR_SEEDS [MAX_VARS] = '{
        16'hACE1, 16'h1B72, 16'h3C93, 16'h7D24,
        16'h9E55, 16'hE1F6, 16'h4A67, 16'h6B89
    };
    localparam logic [15:0] CONST_SEED = 16'h5D38;

    // Right-shift Galois toggle masks; bit k-1 set for polynomial term x^k.
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] taps;
        case (width)
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/sc_stream_gen_lfsr.sv
// Maximal-length Galois LFSR that restarts from its seed on load and steps on advance.
module sc_lfsr
    import sc_sng_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] state
);

    localparam logic [15:0]      TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] state_next;

    always_comb begin
        state_next = state >> 1;
        if (state[0]) begin
            state_next = (state >> 1) ^ TAPS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (advance) begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/sc_stream_gen.sv
// Stochastic number generator bank feeding the canonical-form AND-OR stage.
// Define SC_SNG_SHARED_LFSR_EN to make all variables share one comparison LFSR.
module sc_stream_gen
    import sc_sng_pkg::*;
#(
    parameter int NUM_VARS   = 2,
    parameter int NUM_CONSTS = 2,
    parameter int PREC       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NUM_VARS*PREC-1:0] values,
    input  logic [15:0]              len,
    output logic                     busy,
    output logic                     done,
    output logic                     bit_valid,
    output logic [NUM_VARS-1:0]      var_inputs,
    output logic [NUM_CONSTS-1:0]    const_inputs
);

`ifdef SC_SNG_SHARED_LFSR_EN
    localparam int NUM_LFSR = 1;
`else
    localparam int NUM_LFSR = NUM_VARS;
`endif

    sng_state_t               state;
    sng_state_t               state_next;
    logic [15:0]              remaining;
    logic [NUM_VARS*PREC-1:0] values_q;
    logic                     load;
    logic                     advance;
    logic [PREC-1:0]          var_lfsr [NUM_LFSR];
    logic [PREC-1:0]          const_state;
    logic                     unused_const_bits;

    assign load    = (state == ST_IDLE) && start;
    assign advance = (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            values_q  <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                remaining <= len;
                values_q  <= values;
            end else if (advance && (remaining != 16'd0)) begin
                remaining <= remaining - 16'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (len != 16'd0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (remaining == 16'd1) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign bit_valid = (state == ST_RUN);

    for (genvar g = 0; g < NUM_LFSR; g++) begin : g_var_lfsr
        localparam logic [15:0]     SEED_FULL = VAR_SEEDS[g];
        localparam logic [PREC-1:0] SEED_G    = SEED_FULL[PREC-1:0];
        sc_lfsr #(
            .WIDTH (PREC),
            .SEED  (SEED_G)
        ) u_lfsr (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load),
            .advance (advance),
            .state   (var_lfsr[g])
        );
    end

    localparam logic [PREC-1:0] CONST_SEED_P = CONST_SEED[PREC-1:0];

    sc_lfsr #(
        .WIDTH (PREC),
        .SEED  (CONST_SEED_P)
    ) u_const_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .advance (advance),
        .state   (const_state)
    );

    // With a shared LFSR every variable compares against instance 0, giving SCC=+1 streams.
    for (genvar i = 0; i < NUM_VARS; i++) begin : g_var_bit
        localparam int LFSR_IDX = (NUM_LFSR == 1) ? 0 : i;
        assign var_inputs[i] = bit_valid && (values_q[i*PREC +: PREC] >= var_lfsr[LFSR_IDX]);
    end

    assign const_inputs      = bit_valid ? const_state[NUM_CONSTS-1:0] : '0;
    assign unused_const_bits = ^const_state[PREC-1:NUM_CONSTS];

endmodule

// File: tb/tb_sc_stream_gen.sv
// Self-checking bench for sc_stream_gen (PREC=8, two variables, two const bits).
// Expected streams come from a precomputed period table per seed.
module tb_sc_stream_gen;
    import sc_sng_pkg::*;

    localparam int PREC   = 8;
    localparam int PERIOD = 255;
    localparam int MAXOBS = 600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] values = '0;
    logic [15:0] len = '0;
    logic        busy;
    logic        done;
    logic        bit_valid;
    logic [1:0]  var_inputs;
    logic [1:0]  const_inputs;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] seq_v0 [PERIOD];
    logic [7:0] seq_v1 [PERIOD];
    logic [7:0] seq_c  [PERIOD];

    logic       ob_valid [MAXOBS];
    logic       ob_done  [MAXOBS];
    logic       ob_busy  [MAXOBS];
    logic [1:0] ob_var   [MAXOBS];
    logic [1:0] ob_const [MAXOBS];

    sc_stream_gen #(
        .NUM_VARS   (2),
        .NUM_CONSTS (2),
        .PREC       (PREC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .values       (values),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .bit_valid    (bit_valid),
        .var_inputs   (var_inputs),
        .const_inputs (const_inputs)
    );

    always #5 clk = ~clk;

    // The k-th value a maximal-length Galois generator visits, starting from its seed.
    task automatic build_sequence(input logic [15:0] seed_full, output logic [7:0] seq [PERIOD]);
        logic [15:0] taps_full;
        logic [7:0]  s;
        taps_full = lfsr_taps(PREC);
        s = seed_full[7:0];
        for (int k = 0; k < PERIOD; k++) begin
            seq[k] = s;
            s = s[0] ? ((s >> 1) ^ taps_full[7:0]) : (s >> 1);
        end
    endtask

    function automatic logic [1:0] exp_var(input logic [15:0] vals, input int k);
        logic [1:0] r;
        r[0] = (vals[7:0]  >= seq_v0[k]);
        r[1] = (vals[15:8] >= seq_v1[k]);
        return r;
    endfunction

    // Launch one run and record n cycles of outputs; cycle 0 is the first cycle after start.
    task automatic capture(input logic [15:0] vals, input logic [15:0] run_len,
                           input int n, input int restart_at);
        @(negedge clk);
        start  = 1'b1;
        values = vals;
        len    = run_len;
        @(negedge clk);
        start  = 1'b0;
        values = 16'($urandom);
        len    = 16'($urandom);
        for (int k = 0; k < n; k++) begin
            ob_valid[k] = bit_valid;
            ob_done[k]  = done;
            ob_busy[k]  = busy;
            ob_var[k]   = var_inputs;
            ob_const[k] = const_inputs;
            if (k == restart_at) begin
                start = 1'b1;
                len   = 16'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b1;
        values = 16'($urandom);
        len    = 16'd5;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({busy, done, bit_valid, var_inputs, const_inputs} !== 7'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_hold outputs=%b expected=0", {busy, done, bit_valid, var_inputs, const_inputs});
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if ({busy, done, bit_valid, var_inputs, const_inputs} !== 7'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_idle outputs=%b expected=0", {busy, done, bit_valid, var_inputs, const_inputs});
            end
        end
    endtask

    task automatic test_full_period();
        int cnt0, cnt1, busy_cnt, done_cnt, valid_cnt;
        cnt0 = 0; cnt1 = 0; busy_cnt = 0; done_cnt = 0; valid_cnt = 0;
        capture(16'hFF00, 16'd255, 258, -1);
        for (int k = 0; k < 258; k++) begin
            busy_cnt  += int'(ob_busy[k]);
            done_cnt  += int'(ob_done[k]);
            valid_cnt += int'(ob_valid[k]);
            cnt0      += int'(ob_var[k][0]);
            cnt1      += int'(ob_var[k][1]);
        end
        for (int k = 0; k < PERIOD; k++) begin
            vectors++;
            if (ob_valid[k] !== 1'b1 || ob_var[k] !== exp_var(16'hFF00, k) || ob_const[k] !== seq_c[k][1:0]) begin
                miscompares++;
                $display("[TB] FAIL full_bits k=%0d got v=%b var=%b c=%b expected v=1 var=%b c=%b",
                         k, ob_valid[k], ob_var[k], ob_const[k], exp_var(16'hFF00, k), seq_c[k][1:0]);
            end
        end
        vectors++;
        if (ob_done[255] !== 1'b1 || ob_valid[255] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_done_cycle done=%b valid=%b expected done=1 valid=0", ob_done[255], ob_valid[255]);
        end
        vectors++;
        if (cnt0 != 0 || cnt1 != 255 || valid_cnt != 255) begin
            miscompares++;
            $display("[TB] FAIL full_counts var0=%0d var1=%0d valid=%0d expected 0 255 255", cnt0, cnt1, valid_cnt);
        end
        vectors++;
        if (busy_cnt != 256 || done_cnt != 1) begin
            miscompares++;
            $display("[TB] FAIL full_busy busy=%0d done=%0d expected 256 1", busy_cnt, done_cnt);
        end
    endtask

    task automatic test_counts();
        int cnt0, cnt1;
        int hist [4];
        cnt0 = 0; cnt1 = 0;
        for (int p = 0; p < 4; p++) hist[p] = 0;
        capture({8'd37, 8'd100}, 16'd255, 257, -1);
        for (int k = 0; k < PERIOD; k++) begin
            cnt0 += int'(ob_var[k][0]);
            cnt1 += int'(ob_var[k][1]);
            hist[ob_const[k]]++;
            vectors++;
            if (ob_var[k] !== exp_var({8'd37, 8'd100}, k)) begin
                miscompares++;
                $display("[TB] FAIL counts_bits k=%0d got=%b expected=%b", k, ob_var[k], exp_var({8'd37, 8'd100}, k));
            end
        end
        vectors++;
        if (cnt0 != 100 || cnt1 != 37) begin
            miscompares++;
            $display("[TB] FAIL counts_ones var0=%0d var1=%0d expected 100 37", cnt0, cnt1);
        end
        vectors++;
        if (hist[0] != 63 || hist[1] != 64 || hist[2] != 64 || hist[3] != 64) begin
            miscompares++;
            $display("[TB] FAIL const_hist %0d/%0d/%0d/%0d expected 63/64/64/64", hist[0], hist[1], hist[2], hist[3]);
        end
    endtask

    task automatic test_random_runs();
        logic [15:0] vals;
        int          l;
        for (int r = 0; r < 6; r++) begin
            vals = 16'($urandom);
            l    = int'($urandom_range(1, 40));
            capture(vals, 16'(l), l + 3, -1);
            for (int k = 0; k < l + 3; k++) begin
                vectors++;
                if (ob_valid[k] !== (k < l) || ob_done[k] !== (k == l) || ob_busy[k] !== (k <= l) ||
                    ob_var[k] !== ((k < l) ? exp_var(vals, k) : 2'b00) ||
                    ob_const[k] !== ((k < l) ? seq_c[k][1:0] : 2'b00)) begin
                    miscompares++;
                    $display("[TB] FAIL random_run r=%0d len=%0d k=%0d got v=%b d=%b b=%b var=%b c=%b",
                             r, l, k, ob_valid[k], ob_done[k], ob_busy[k], ob_var[k], ob_const[k]);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        capture(16'($urandom), 16'd0, 4, -1);
        vectors++;
        if (ob_done[0] !== 1'b1 || ob_busy[0] !== 1'b1 || ob_valid[0] !== 1'b0 || ob_var[0] !== 2'b00 || ob_const[0] !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL zero_len_done d=%b b=%b v=%b expected d=1 b=1 v=0", ob_done[0], ob_busy[0], ob_valid[0]);
        end
        for (int k = 1; k < 4; k++) begin
            vectors++;
            if (ob_busy[k] !== 1'b0 || ob_done[k] !== 1'b0 || ob_valid[k] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL zero_len_idle k=%0d b=%b d=%b v=%b expected 0", k, ob_busy[k], ob_done[k], ob_valid[k]);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [15:0] vals;
        vals = 16'($urandom);
        capture(vals, 16'd20, 24, 5);
        for (int k = 0; k < 24; k++) begin
            vectors++;
            if (ob_valid[k] !== (k < 20) || ob_done[k] !== (k == 20) || ob_busy[k] !== (k <= 20) ||
                ob_var[k] !== ((k < 20) ? exp_var(vals, k) : 2'b00)) begin
                miscompares++;
                $display("[TB] FAIL start_in_run k=%0d got v=%b d=%b b=%b var=%b", k, ob_valid[k], ob_done[k], ob_busy[k], ob_var[k]);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] vals;
        logic [1:0]  first_var   [50];
        logic [1:0]  first_const [50];
        vals = 16'($urandom);
        @(negedge clk);
        start  = 1'b1;
        values = vals;
        len    = 16'd255;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            first_var[k]   = var_inputs;
            first_const[k] = const_inputs;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, bit_valid, var_inputs, const_inputs} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_immediate outputs=%b expected=0", {busy, done, bit_valid, var_inputs, const_inputs});
        end
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL abort_no_done done=%b expected=0", done);
            end
        end
        rst_n = 1'b1;
        capture(vals, 16'd255, 60, -1);
        for (int k = 0; k < 50; k++) begin
            vectors++;
            if (ob_var[k] !== first_var[k] || ob_const[k] !== first_const[k] || ob_var[k] !== exp_var(vals, k)) begin
                miscompares++;
                $display("[TB] FAIL abort_replay k=%0d got var=%b c=%b first var=%b c=%b model var=%b",
                         k, ob_var[k], ob_const[k], first_var[k], first_const[k], exp_var(vals, k));
            end
        end
        repeat (200) @(negedge clk);
    endtask

    task automatic test_equal_values();
        int cnt0, cnt1, diffs;
        cnt0 = 0; cnt1 = 0; diffs = 0;
        capture(16'h6464, 16'd255, 257, -1);
        for (int k = 0; k < PERIOD; k++) begin
            cnt0  += int'(ob_var[k][0]);
            cnt1  += int'(ob_var[k][1]);
            diffs += int'(ob_var[k][0] != ob_var[k][1]);
        end
        vectors++;
        if (cnt0 != 100 || cnt1 != 100) begin
            miscompares++;
            $display("[TB] FAIL equal_counts var0=%0d var1=%0d expected 100 100", cnt0, cnt1);
        end
        vectors++;
`ifdef SC_SNG_SHARED_LFSR_EN
        if (diffs != 0) begin
            miscompares++;
            $display("[TB] FAIL equal_shared diff_cycles=%0d expected 0", diffs);
        end
`else
        if (diffs == 0) begin
            miscompares++;
            $display("[TB] FAIL equal_independent diff_cycles=%0d expected >0", diffs);
        end
`endif
    endtask

    initial begin
        build_sequence(VAR_SEEDS[0], seq_v0);
`ifdef SC_SNG_SHARED_LFSR_EN
        build_sequence(VAR_SEEDS[0], seq_v1);
`else
        build_sequence(VAR_SEEDS[1], seq_v1);
`endif
        build_sequence(CONST_SEED, seq_c);

        test_reset();
        test_full_period();
        test_counts();
        test_random_runs();
        test_zero_len();
        test_start_ignored();
        test_reset_abort();
        test_equal_values();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sc_stream_gen.md
# sc_stream_gen

Stochastic number generator bank that sits directly upstream of the canonical-form AND-OR stage. It converts latched binary probabilities into `NUM_VARS` unipolar bitstreams (`var_inputs`) and generates the `NUM_CONSTS` uniform random selection bits (`const_inputs`) that the canonical-form stage consumes. Each run is started by a pulse and lasts a programmable number of cycles. `bit_valid` qualifies every emitted bit, and `done` marks the end of the run.

## Interface
- `NUM_VARS`, 2: number of variable bitstreams.
- `NUM_CONSTS`, 2: number of constant random bits; must satisfy `PREC >= NUM_CONSTS+1`.
- `PREC`, 8: value precision and LFSR width; supported range 4..16.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: run request; sampled only in IDLE.
- `values` in `NUM_VARS*PREC`: unsigned probability per variable; variable i occupies `[i*PREC +: PREC]`.
- `len` in 16: run length in cycles.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse when a run ends.
- `bit_valid` out 1: high in every RUN cycle.
- `var_inputs` out `NUM_VARS`: stochastic bits.
- `const_inputs` out `NUM_CONSTS`: random selection bits.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN: `start`=1 and `len`≠0.
  - IDLE→DONE: `start`=1 and `len`=0.
  - RUN→DONE: when `remaining`=1.
  - DONE→IDLE: unconditionally.
- Start actions: on `start` in IDLE, latch `values`, load `remaining`=`len`, and load every LFSR with its package seed. Every run is therefore bit-reproducible.
- `start` in RUN or DONE is ignored and has no other effect.
- LFSRs: Galois, maximal length, width `PREC`, state range 1..2^PREC−1. Per-width taps come from the package.
  - One LFSR per variable, each with a distinct seed.
  - One further LFSR (const seed) drives `const_inputs`.
  - All LFSRs advance once per RUN cycle.
- Variable bit: `var_inputs[i]` = (`value_i` >= `lfsr_i`), unsigned compare.
  - Over one full period (`len`=2^PREC−1), exactly `value_i` ones are produced.
  - `value`=0 never produces a one.
- Constant bits: `const_inputs` = low `NUM_CONSTS` bits of the const LFSR. Over a full period, each nonzero pattern appears 2^(PREC−NUM_CONSTS) times and the all-zero pattern appears one time fewer.
- Output gating: `var_inputs` and `const_inputs` are forced to 0 whenever `bit_valid`=0.
- `remaining` decrements every RUN cycle and does not wrap.

## Timing
- Reset values: all outputs 0, state IDLE, LFSRs at seeds, `remaining`=0.
- Reset asserted mid-run: aborts immediately, no `done` pulse.
- Latency:
  - `start` seen at edge t → first `bit_valid` in cycle t+1, using the seed states.
  - Bits are produced in cycles t+1..t+`len`.
  - `done`=1 in cycle t+`len`+1.
  - Earliest IDLE is cycle t+`len`+2, so the minimum start-to-start spacing is `len`+2 cycles.
- `len`=0: `done` in cycle t+1, no `bit_valid`.
- Outputs in RUN are a combinational function of registered state (LFSRs, latched values). There is no combinational path from `start`, `values` or `len` to any output.

## Configuration
- `SC_SNG_SHARED_LFSR_EN` defined: all variables compare against a single variable LFSR (variable-0 seed). Streams are maximally correlated (SCC=+1), and equal values give identical streams.
- Undefined: independent per-variable LFSRs as described under Operation.
- The const LFSR stays separate in both cases.

## Structure
- Package `sc_sng_pkg`:
  - FSM state enum.
  - Tap-mask function indexed by width 4..16.
  - Seed constants: per-variable array plus `CONST_SEED`; all nonzero and pairwise distinct.
- Sub-module `sc_lfsr` (parameters `WIDTH`, `SEED`; ports `clk`, `rst_n`, `load`, `advance`, `state`), instantiated `NUM_VARS`+1 times, or 2 times when shared.

## Test plan
- Reset: hold `rst_n`=0 → `busy`, `done`, `bit_valid`, `var_inputs` and `const_inputs` all 0. Release → no activity without `start`.
- `PREC`=8, `values`={255,0}, `len`=255 → 255 `bit_valid` cycles, var1 count 255, var0 count 0, `done` exactly one cycle after the last valid bit, `busy` high for 256 cycles.
- `values`={100,37}, `len`=255, `NUM_CONSTS`=2 → counts exactly 100 and 37; const patterns 01/10/11 appear 64 times each and 00 appears 63 times.
- `len`=0 → no `bit_valid`, `done` one cycle after `start`, back in IDLE the cycle after. `start` pulsed during RUN → ignored, run length unchanged.
- Reset asserted at cycle 50 of a 255-cycle run → outputs 0 immediately, no `done`. A new run with the same inputs reproduces the first run's bit sequence exactly.
- `values`={100,100}: with `SC_SNG_SHARED_LFSR_EN` → var0 equals var1 every cycle. Without the macro → the streams differ in at least one cycle, each still counting 100.
